// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped 16x1-word write-through, no-write-allocate data cache controller
// Freezes the core pipeline through `waiting` while a refill or write-through is outstanding.
module dcache_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wstrb,
  output logic [31:0] core_rdata,
  output logic        waiting,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  typedef enum logic [1:0] {IDLE, MISS, WR, DONE} state_t;

  state_t      state;
  logic [15:0] valid;
  logic [25:0] tag_arr  [16];
  logic [31:0] data_arr [16];

  logic [31:2] lat_addr;
  logic        lat_hit;

  logic [3:0]  idx;
  logic [3:0]  lat_idx;
  logic        hit;
  logic        unused_addr_bits;

  assign idx              = core_addr[5:2];
  assign lat_idx          = lat_addr[5:2];
  assign hit              = valid[idx] && (tag_arr[idx] == core_addr[31:6]);
  assign unused_addr_bits = ^core_addr[1:0];

  assign waiting = ((state == IDLE) && core_req && (core_we || !hit)) ||
                   (state == MISS) || (state == WR);

  always_comb begin
    core_rdata = data_arr[idx];
    if (state == DONE) core_rdata = data_arr[lat_idx];
  end

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    return res;
  endfunction

  // The mem_wdata/mem_wstrb registers double as the latched store data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      lat_addr  <= '0;
      lat_hit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (core_req) begin
            lat_addr <= core_addr[31:2];
            lat_hit  <= hit;
            if (core_we) begin
              state     <= WR;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {core_addr[31:2], 2'b00};
              mem_wdata <= core_wdata;
              mem_wstrb <= core_wstrb;
              if (hit) hit_cnt  <= hit_cnt + 32'd1;
              else     miss_cnt <= miss_cnt + 32'd1;
            end else if (!hit) begin
              state    <= MISS;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {core_addr[31:2], 2'b00};
              miss_cnt <= miss_cnt + 32'd1;
            end else begin
              hit_cnt <= hit_cnt + 32'd1;
            end
          end
        end
        MISS: begin
          if (mem_ready) begin
            valid[lat_idx] <= 1'b1;
            mem_req        <= 1'b0;
            state          <= DONE;
          end
        end
        WR: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid bits alone decide whether contents matter.
  always_ff @(posedge clk) begin
    if (state == MISS && mem_ready) begin
      tag_arr[lat_idx]  <= lat_addr[31:6];
      data_arr[lat_idx] <= mem_rdata;
    end else if (state == WR && mem_ready && lat_hit) begin
      data_arr[lat_idx] <= merge_bytes(data_arr[lat_idx], mem_wdata, mem_wstrb);
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
// Reference model: cache contents as per-index arrays plus a sparse backing memory.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_wstrb;
  logic [31:0] core_rdata;
  logic        waiting;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt, miss_cnt;

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_wstrb(core_wstrb), .core_rdata(core_rdata),
    .waiting(waiting),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic        mvalid [16];
  logic [25:0] mtag   [16];
  logic [31:0] mdata  [16];
  logic [31:0] bmem   [logic [29:0]];
  logic [31:0] m_hit, m_miss;
  logic [31:0] last_rdata;
  int          last_waits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (bmem.exists(a[31:2])) return bmem[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    m_hit  = 0;
    m_miss = 0;
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int lat);
    int   i;
    logic h;
    int   waits;
    i = int'(addr[5:2]);
    @(negedge clk);
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
    mem_ready  = 1'b0;
    core_req   = 1'b1;
    core_we    = we;
    core_addr  = addr;
    core_wdata = wdata;
    core_wstrb = wstrb;
    #1;
    h = mvalid[i] && (mtag[i] == addr[31:6]);
    if (!we && h) begin
      chk("hit_waiting", {31'b0, waiting}, 32'd0);
      chk("hit_rdata", core_rdata, mdata[i]);
      chk("hit_mem_req", {31'b0, mem_req}, 32'd0);
      last_rdata = core_rdata;
      last_waits = 0;
      m_hit++;
      return;
    end
    chk("issue_waiting", {31'b0, waiting}, 32'd1);
    waits = 1;
    if (h) m_hit++;
    else   m_miss++;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      mem_ready = (k == lat - 1);
      mem_rdata = mem_ready ? mem_word(addr) : $urandom;
      #1;
      chk("busy_waiting", {31'b0, waiting}, 32'd1);
      chk("busy_mem_req", {31'b0, mem_req}, 32'd1);
      chk("busy_mem_we", {31'b0, mem_we}, {31'b0, we});
      chk("busy_mem_addr", mem_addr, {addr[31:2], 2'b00});
      if (we) begin
        chk("busy_mem_wdata", mem_wdata, wdata);
        chk("busy_mem_wstrb", {28'b0, mem_wstrb}, {28'b0, wstrb});
      end
      waits++;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    #1;
    chk("done_waiting", {31'b0, waiting}, 32'd0);
    chk("done_mem_req", {31'b0, mem_req}, 32'd0);
    if (!we) begin
      mvalid[i] = 1'b1;
      mtag[i]   = addr[31:6];
      mdata[i]  = mem_word(addr);
      chk("done_rdata", core_rdata, mdata[i]);
      last_rdata = core_rdata;
    end else begin
      bmem[addr[31:2]] = merge(mem_word(addr), wdata, wstrb);
      if (h) mdata[i] = merge(mdata[i], wdata, wstrb);
    end
    last_waits = waits;
  endtask

  task automatic idle(input int n, input logic noise);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      core_req  = 1'b0;
      core_we   = 1'($urandom);
      mem_ready = noise ? 1'($urandom) : 1'b0;
      mem_rdata = $urandom;
      #1;
      chk("idle_waiting", {31'b0, waiting}, 32'd0);
      chk("idle_mem_req", {31'b0, mem_req}, 32'd0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] base_miss;
    rst        = 1'b1;
    core_req   = 1'b0;
    core_we    = 1'b0;
    core_addr  = '0;
    core_wdata = '0;
    core_wstrb = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    model_reset();
    bmem[30'h40] = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    chk("rst_waiting", {31'b0, waiting}, 32'd0);
    rst = 1'b0;
    idle(2, 1'b1);

    access(1'b0, 32'h100, 32'h0, 4'h0, 3);
    chk("d32_waits", last_waits, 32'd4);
    chk("d32_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("d32_miss_cnt", miss_cnt, 32'd1);

    access(1'b0, 32'h100, 32'h0, 4'h0, 1);
    chk("d33_waits", last_waits, 32'd0);
    chk("d33_rdata", last_rdata, 32'hDEAD_BEEF);

    access(1'b1, 32'h100, 32'h0000_00AA, 4'b0001, 2);
    access(1'b0, 32'h100, 32'h0, 4'h0, 1);
    chk("d34_waits", last_waits, 32'd0);
    chk("d34_rdata", last_rdata, 32'hDEAD_BEAA);

    base_miss = m_miss;
    access(1'b1, 32'h200, 32'h1234_5678, 4'b1111, 2);
    access(1'b0, 32'h200, 32'h0, 4'h0, 2);
    chk("d35_rdata", last_rdata, 32'h1234_5678);
    chk("d35_miss_delta", m_miss - base_miss, 32'd2);

    access(1'b0, 32'h140, 32'h0, 4'h0, 1);
    chk("d36_first_waits", last_waits, 32'd2);
    access(1'b0, 32'h100, 32'h0, 4'h0, 1);
    chk("d36_refetch_rdata", last_rdata, 32'hDEAD_BEAA);
    idle(1, 1'b0);

    // Randomised traffic over a small tag set so hits, conflicts and stores all recur.
    for (int n = 0; n < 300; n++) begin
      a = {24'($urandom_range(0, 3)) << 2, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      access(1'($urandom_range(0, 2) == 0), a, $urandom, 4'($urandom), $urandom_range(1, 5));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3), 1'b1);
    end
    idle(1, 1'b0);
    #1;
    chk("rand_hit_cnt", hit_cnt, m_hit);
    chk("rand_miss_cnt", miss_cnt, m_miss);

    // Reset while a refill is outstanding, then a stray completion strobe.
    @(negedge clk);
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 32'hFFFF_FFC0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_pre_mem_req", {31'b0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
    chk("abort_hit_cnt", hit_cnt, 32'd0);
    chk("abort_miss_cnt", miss_cnt, 32'd0);
    model_reset();
    @(negedge clk);
    core_req = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("stray_mem_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("stray_after_mem_req", {31'b0, mem_req}, 32'd0);
    chk("stray_waiting", {31'b0, waiting}, 32'd0);
    chk("stray_miss_cnt", miss_cnt, 32'd0);
    for (int i = 0; i < 16; i++)
      access(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h0, 1);
    access(1'b0, 32'hFFFF_FFC0, 32'h0, 4'h0, 1);
    chk("abort_no_fill_waits", last_waits, 32'd2);
    idle(1, 1'b0);
    #1;
    chk("final_miss_cnt", miss_cnt, 32'd17);
    chk("final_hit_cnt", hit_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
